// File: rtl/reg_move_seq.sv
// Register-move sequencer: accepts one command at a time and drives the
// register file strobe sequence for NOP/MOV/LDI/INC/DEC/SWAP/MOVU/RD.
module reg_move_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [5:0]  cmd_src,
  input  logic [5:0]  cmd_dst,
  input  logic [15:0] cmd_imm,
  input  logic [15:0] rf_dout,
  output logic [15:0] rf_din,
  output logic [5:0]  rf_id,
  output logic        rf_read,
  output logic        rf_readu,
  output logic        rf_write,
  output logic        rf_writeu,
  output logic        rf_inc,
  output logic        rf_dec,
  output logic        done,
  output logic [15:0] result
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_DEC  = 3'b100;
  localparam logic [2:0] OP_SWAP = 3'b101;
  localparam logic [2:0] OP_MOVU = 3'b110;
  localparam logic [2:0] OP_RD   = 3'b111;

  typedef enum logic [2:0] {
    IDLE, RD1, RD2, WR1, WR2, STEP, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  op;
  logic [5:0]  src, dst;
  logic [15:0] imm, temp_a, temp_b;

  // Strobes are decoded from state only, so reset clears them immediately.
  always_comb begin
    state_nxt = state;
    rf_id     = '0;
    rf_din    = '0;
    rf_read   = 1'b0;
    rf_readu  = 1'b0;
    rf_write  = 1'b0;
    rf_writeu = 1'b0;
    rf_inc    = 1'b0;
    rf_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP:                          state_nxt = DONE;
            OP_MOV, OP_MOVU, OP_RD, OP_SWAP: state_nxt = RD1;
            OP_LDI:                          state_nxt = WR1;
            default:                         state_nxt = STEP;
          endcase
        end
      end
      RD1: begin
        rf_id = src;
        if (op == OP_MOVU) rf_readu = 1'b1;
        else               rf_read  = 1'b1;
        if (op == OP_RD)        state_nxt = DONE;
        else if (op == OP_SWAP) state_nxt = RD2;
        else                    state_nxt = WR1;
      end
      RD2: begin
        rf_id     = dst;
        rf_read   = 1'b1;
        state_nxt = WR1;
      end
      WR1: begin
        rf_id  = dst;
        rf_din = (op == OP_LDI) ? imm : temp_a;
        if (op == OP_MOVU) rf_writeu = 1'b1;
        else               rf_write  = 1'b1;
        state_nxt = (op == OP_SWAP) ? WR2 : DONE;
      end
      WR2: begin
        rf_id     = src;
        rf_din    = temp_b;
        rf_write  = 1'b1;
        state_nxt = DONE;
      end
      STEP: begin
        rf_id = dst;
        if (op == OP_INC) rf_inc = 1'b1;
        else              rf_dec = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op     <= OP_NOP;
      src    <= '0;
      dst    <= '0;
      imm    <= '0;
      temp_a <= '0;
      temp_b <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        op  <= cmd_op;
        src <= cmd_src;
        dst <= cmd_dst;
        imm <= cmd_imm;
      end
      if (state == RD1) temp_a <= rf_dout;
      if (state == RD2) temp_b <= rf_dout;
      // RD finishes straight from RD1, so its result bypasses temp_a.
      if (state == RD1 && op == OP_RD) result <= rf_dout;
      if (state == WR1 && state_nxt == DONE) result <= (op == OP_LDI) ? imm : temp_a;
      if (state == WR2) result <= temp_a;
    end
  end

endmodule

// File: doc/reg_move_seq.md
REG_MOVE_SEQ -- requirements
Module: reg_move_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all other state changes occur on the rising edge of clk.
REQ-002 clk  in  1  system clock, rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  sequencer idle; command accepted on clk edge when cmd_valid & cmd_ready.
REQ-006 cmd_op  in  3  000 NOP, 001 MOV, 010 LDI, 011 INC, 100 DEC, 101 SWAP, 110 MOVU, 111 RD.
REQ-007 cmd_src  in  6  source register id.
REQ-008 cmd_dst  in  6  destination register id.
REQ-009 cmd_imm  in  16  immediate for LDI.
REQ-010 rf_dout  in  16  register file read data, combinational from rf_id and rf_read/rf_readu.
REQ-011 rf_din  out  16  register file write data.
REQ-012 rf_id  out  6  register file select.
REQ-013 rf_read, rf_readu, rf_write, rf_writeu, rf_inc, rf_dec  out  1 each  register file strobes; register file acts on rf_write/rf_writeu/rf_inc/rf_dec at the next clk edge.
REQ-014 done  out  1  one-cycle pulse at command completion.
REQ-015 result  out  16  value from last completed command.

Function
REQ-016 States SHALL be IDLE, RD1, RD2, WR1, WR2, STEP, DONE; cmd_ready = 1 only in IDLE.
REQ-017 On acceptance, op/src/dst/imm SHALL be latched; later changes to cmd_* are ignored until the next IDLE.
REQ-018 Transitions from IDLE: NOP->DONE; MOV, MOVU, RD, SWAP->RD1; LDI->WR1; INC, DEC->STEP.
REQ-019 RD1: rf_id=src; rf_readu=1 for MOVU, else rf_read=1; tempA <= rf_dout at edge. Next state: RD->DONE, SWAP->RD2, else WR1.
REQ-020 RD2 (SWAP only): rf_id=dst, rf_read=1, tempB <= rf_dout; next WR1.
REQ-021 WR1: rf_id=dst; rf_din=imm for LDI, else tempA; rf_writeu=1 for MOVU, else rf_write=1. Next: SWAP->WR2, else DONE.
REQ-022 WR2 (SWAP only): rf_id=src, rf_din=tempB, rf_write=1; next DONE.
REQ-023 STEP: rf_id=dst, rf_inc=1 (INC) or rf_dec=1 (DEC); next DONE.
REQ-024 DONE: done=1 for exactly one cycle; next IDLE; a new command can be accepted no earlier than the cycle after DONE.
REQ-025 At most one rf strobe SHALL be high in any cycle; all strobes are 0 in IDLE and DONE; rf_id=0 and rf_din=0 when no strobe is active.
REQ-026 result SHALL update on entry to DONE: MOV/MOVU/RD/SWAP = tempA; LDI = imm; NOP/INC/DEC leave it unchanged.
REQ-027 Latency from acceptance edge to done: NOP 1, LDI/INC/DEC/RD 2, MOV/MOVU 3, SWAP 5 cycles.
REQ-028 SWAP with src==dst SHALL execute all steps; the register keeps its original value.
REQ-029 cmd_valid while not IDLE SHALL have no effect and SHALL NOT be queued.
REQ-030 Widths are fixed at 16-bit data and 6-bit id, with no arithmetic performed in this block.

Reset
REQ-031 rst SHALL immediately force: state IDLE, cmd_ready=1, done=0, all rf strobes 0, rf_id=0, rf_din=0, tempA=tempB=0, result=0.
REQ-032 rst mid-command SHALL abort it with no further strobes; a write whose strobe is deasserted by reset before the edge does not occur; no done pulse is produced.
REQ-033 After rst deasserts, the first rising clk edge SHALL be able to accept a command.

Verification
REQ-034 LDI dst=1 imm=0x0F0F, then RD src=1 -> WR1 shows rf_write=1, rf_id=1, rf_din=0x0F0F; RD done two cycles after acceptance with result=0x0F0F.
REQ-035 MOV src=1 dst=0 (R1=0x1F0F) -> RD1 rf_read rf_id=1, WR1 rf_write rf_id=0 rf_din=0x1F0F; done at cycle 3; result=0x1F0F.
REQ-036 SWAP src=0 (0x1234) dst=1 (0xABCD) -> strobe sequence read, read, write(id1, 0x1234), write(id0, 0xABCD); done at cycle 5; result=0x1234.
REQ-037 INC dst=0 then DEC dst=0 -> exactly one cycle each of rf_inc=1 and rf_dec=1 with rf_id=0; result unchanged; cmd_valid held high while busy accepts nothing extra.
REQ-038 Assert rst during the WR1 cycle of MOV -> strobes drop to 0 asynchronously, no done pulse, cmd_ready=1, result=0.
REQ-039 MOVU src=2 dst=3 -> RD1 rf_readu=1 (rf_read=0), WR1 rf_writeu=1 (rf_write=0); one-hot strobe check holds in every cycle.
